// File: rtl/softmax_in_packer.sv
// Streams Q6.10 logits into an N-lane vector for the softmax block.
// Short vectors are padded with PAD_VAL. Over-long vectors are truncated and raise a sticky error.

module softmax_in_packer_lane #(
  parameter int          LANE    = 0,
  parameter int          IW      = 6,
  parameter logic [15:0] PAD_VAL = 16'h8000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [IW-1:0] idx,
  input  logic [15:0]   s_data,
  output logic [15:0]   lane_val
);
  logic [15:0] fill_q;
  logic        hit, above;

  assign hit   = (idx == IW'(LANE));
  assign above = (idx < IW'(LANE));

  always_ff @(posedge clk) begin
    if (rst)            fill_q <= '0;
    else if (wr && hit) fill_q <= s_data;
  end

  // The completing element bypasses the fill register, and lanes beyond it are masked to PAD_VAL.
  // This lets the vector be emitted on the very next cycle.
  assign lane_val = hit ? s_data : (above ? PAD_VAL : fill_q);
endmodule

module softmax_in_packer #(
  parameter int          N       = 64,
  parameter logic [15:0] PAD_VAL = 16'h8000,
  parameter int          LW      = $clog2(N+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [15:0]     s_data,
  input  logic            s_last,
  output logic [N*16-1:0] in_x_flat,
  output logic            valid_in,
  output logic [LW-1:0]   vec_len,
  output logic            short_vec,
  output logic            err_long
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {FILL, DROP} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               accept, at_end, done, set_err, pend_q;
  logic [N-1:0][15:0] lane_vals;

  assign s_ready = en & ~rst;
  assign accept  = s_valid & s_ready & en;
  assign at_end  = (idx_q == IW'(N-1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done    = 1'b0;
    set_err = 1'b0;
    case (state_q)
      FILL: if (accept) begin
        if (s_last || at_end) begin
          done  = 1'b1;
          idx_d = '0;
          if (!s_last) begin
            state_d = DROP;
            set_err = 1'b1;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DROP: if (accept && s_last) begin
        state_d = FILL;
        idx_d   = '0;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_lane
      softmax_in_packer_lane #(.LANE(i), .IW(IW), .PAD_VAL(PAD_VAL)) u_lane (
        .clk      (clk),
        .rst      (rst),
        .wr       (accept && (state_q == FILL)),
        .idx      (idx_q),
        .s_data   (s_data),
        .lane_val (lane_vals[i])
      );
    end
  endgenerate

  // pend_q holds an emission until it has been shown on an en-high cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_x_flat <= '0;
      vec_len   <= '0;
      short_vec <= 1'b0;
      err_long  <= 1'b0;
      pend_q    <= 1'b0;
    end else if (en) begin
      pend_q   <= done;
      err_long <= err_long | set_err;
      if (done) begin
        in_x_flat <= lane_vals;
        vec_len   <= LW'(idx_q) + LW'(1);
        short_vec <= ~at_end;
      end
    end
  end

  assign valid_in = pend_q & en & ~rst;
endmodule

// File: tb/tb_softmax_in_packer.sv
// Directed and randomized stimulus for softmax_in_packer.
// Outputs are compared each cycle against a queue-based reference model.

module tb_softmax_in_packer;
  localparam int N  = 64;
  localparam int LW = $clog2(N+1);

  logic            clk = 1'b0;
  logic            rst, en, s_valid, s_ready, s_last, valid_in, short_vec, err_long;
  logic [15:0]     s_data;
  logic [N*16-1:0] in_x_flat;
  logic [LW-1:0]   vec_len;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  softmax_in_packer #(.N(N), .PAD_VAL(16'h8000)) dut (
    .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .in_x_flat(in_x_flat), .valid_in(valid_in),
    .vec_len(vec_len), .short_vec(short_vec), .err_long(err_long)
  );

  // Reference model: the current vector is a queue, and the last emission is kept as lanes.
  logic [15:0] cur[$];
  logic [15:0] m_vec[N];
  bit          dropping = 0, m_err = 0, m_pend = 0, m_short = 0;
  int          m_len = 0;
  int          pulses = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flat();
    logic [N*16-1:0] exp_flat;
    for (int i = 0; i < N; i++) exp_flat[16*i +: 16] = m_vec[i];
    checks++;
    assert (in_x_flat === exp_flat) else begin
      failures++;
      for (int i = 0; i < N; i++)
        if (in_x_flat[16*i +: 16] !== exp_flat[16*i +: 16]) begin
          $error("FAIL in_x_flat lane%0d observed=%0h expected=%0h",
                 i, in_x_flat[16*i +: 16], exp_flat[16*i +: 16]);
          break;
        end
    end
  endtask

  task automatic model_edge(bit v, logic [15:0] d, bit l, bit e, bit r);
    if (r) begin
      cur.delete();
      dropping = 0; m_err = 0; m_pend = 0; m_len = 0; m_short = 0;
      for (int i = 0; i < N; i++) m_vec[i] = '0;
    end else if (e) begin
      m_pend = 0;
      if (v) begin
        if (dropping) begin
          if (l) dropping = 0;
        end else begin
          cur.push_back(d);
          if (l || cur.size() == N) begin
            for (int i = 0; i < N; i++) m_vec[i] = (i < cur.size()) ? cur[i] : 16'h8000;
            m_len   = cur.size();
            m_short = (cur.size() < N);
            m_pend  = 1;
            if (!l) begin
              dropping = 1;
              m_err    = 1;
            end
            cur.delete();
          end
        end
      end
    end
  endtask

  // One clock: drive, check outputs mid-cycle, then advance the model across the edge.
  task automatic cyc(bit v, logic [15:0] d, bit l, bit e, bit r);
    s_valid = v; s_data = d; s_last = l; en = e; rst = r;
    #1;
    chk("s_ready", s_ready, e & ~r);
    chk("valid_in", valid_in, m_pend & e & ~r);
    if (valid_in === 1'b1) pulses++;
    chk("err_long", err_long, m_err);
    chk("vec_len", vec_len, m_len);
    chk("short_vec", short_vec, m_short);
    chk_flat();
    @(posedge clk);
    model_edge(v, d, l, e, r);
    #1;
  endtask

  task automatic send(logic [15:0] d, bit l);
    cyc(1, d, l, 1, 0);
  endtask

  // Presents one element under random gaps and en drops until it is accepted.
  task automatic send_rnd(logic [15:0] d, bit l);
    bit v, e;
    for (int t = 0; t < 64; t++) begin
      v = ($urandom_range(3) != 0);
      e = ($urandom_range(7) != 0);
      cyc(v, d, l, e, 0);
      if (v && e) return;
    end
    cyc(1, d, l, 1, 0);
  endtask

  logic [15:0] pat[8];
  int          len, p0;

  initial begin
    pat = '{16'h061D, 16'h061D, 16'hFDE2, 16'h0B13, 16'hFBCF, 16'h0B26, 16'h042B, 16'hF5BE};
    for (int i = 0; i < N; i++) m_vec[i] = '0;
    rst = 1; en = 1; s_valid = 0; s_data = '0; s_last = 0;
    repeat (2) @(posedge clk);
    #1;
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0);

    // Full vector of the repeating pattern.
    for (int i = 0; i < N; i++) send(pat[i%8], i == N-1);
    cyc(0, 0, 0, 1, 0);
    chk("full_lane0", in_x_flat[15:0], 16'h061D);
    chk("full_lane3", in_x_flat[63:48], 16'h0B13);
    chk("full_lane63", in_x_flat[N*16-1 -: 16], 16'hF5BE);

    // Short vector of five elements.
    send(16'h00F7, 0); send(16'h0AC0, 0); send(16'h0A99, 0); send(16'h09D6, 0); send(16'hFF4D, 1);
    cyc(0, 0, 0, 1, 0);
    chk("short_lane5", in_x_flat[95:80], 16'h8000);
    chk("short_len", vec_len, 5);

    // Three vectors back to back.
    p0 = pulses;
    for (int i = 0; i < 3*N; i++) send(16'($urandom), (i % N) == N-1);
    cyc(0, 0, 0, 1, 0);
    chk("b2b_pulses", pulses - p0, 3);

    // Over-long vector of 70 elements, then a normal one.
    for (int i = 0; i < 70; i++) send(16'($urandom), i == 69);
    for (int i = 0; i < N; i++) send(16'($urandom), i == N-1);
    cyc(0, 0, 0, 1, 0);

    // en drops for 3 cycles exactly when the pulse is due.
    for (int i = 0; i < N; i++) send(16'($urandom), i == N-1);
    cyc(1, 16'h1234, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 16'h5678, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);

    // Reset after 20 elements, then a clean vector.
    for (int i = 0; i < 20; i++) send(16'($urandom), 0);
    cyc(1, 16'hAAAA, 1, 1, 1);
    for (int i = 0; i < N; i++) send(16'($urandom), i == N-1);
    cyc(0, 0, 0, 1, 0);

    // Randomized lengths, including over-long ones, with gaps and en drops.
    for (int k = 0; k < 15; k++) begin
      len = $urandom_range(1, 75);
      for (int i = 0; i < len; i++) send_rnd(16'($urandom), i == len-1);
    end
    repeat (3) cyc(0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/softmax_in_packer.md
Name: softmax_in_packer

Overview:
- Upstream feeder for the N-lane softmax block.
- Accepts a stream of Q6.10 logits, one 16-bit element per cycle under valid/ready, and assembles them into the flat N×16 vector the softmax consumes.
- Raises a one-cycle valid with the vector. Pads short vectors with a mask value so padded lanes get ~0 probability. Truncates over-long vectors and flags them.

Parameters:
- N, 64, vector length in elements; must match the softmax N.
- PAD_VAL, 16'h8000, value written to unfilled lanes (most-negative Q6.10).
- LW, $clog2(N+1), width of vec_len.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; when low, all state is frozen.
- s_valid  in  1  input element valid.
- s_ready  out  1  packer can accept an element.
- s_data  in  16  signed Q6.10 logit.
- s_last  in  1  marks the final element of a vector.
- in_x_flat  out  N*16  assembled vector; element i is at bits [16*i +: 16]; connects to softmax in_x_flat.
- valid_in  out  1  one-cycle pulse, vector ready; connects to softmax valid_in.
- vec_len  out  LW  count of real (non-padded) elements in the current in_x_flat, 1..N.
- short_vec  out  1  qualifies valid_in; vector was padded.
- err_long  out  1  sticky; a vector exceeded N elements.

Behaviour:
- Clocking and reset: single clock; rst is synchronous, active-high, and overrides en.
- Reset values: in_x_flat=0, valid_in=0, vec_len=0, short_vec=0, err_long=0, fill index=0, state=FILL. s_ready is 0 while rst=1 and 1 on the first cycle after.
- Storage: a fill register (N×16) plus a separate output register (in_x_flat). No bubble between vectors.
- Accept rule: accept = s_valid & s_ready & en. s_ready = en & ~rst in both states.
- FSM states: FILL, DROP.
- FILL, accept with idx<N-1 and s_last=0:
  - fill[idx] <= s_data; idx++.
- FILL, accept with s_last=1 (idx ≤ N-1), or idx==N-1 (completion):
  - Next cycle: in_x_flat = fill with lane idx = s_data and lanes idx+1..N-1 = PAD_VAL. Padding uses a single-cycle lane mask; no extra cycles.
  - vec_len = idx+1; short_vec = (idx+1<N); valid_in=1; idx <= 0.
  - A new element may be accepted into fill lane 0 on that same next cycle.
- Completion at idx==N-1 with s_last=0: the vector is emitted as above, err_long <= 1, state <= DROP.
- Completion at idx==N-1 with s_last=1: normal, stay in FILL.
- DROP: accepted elements are discarded. When an accepted element has s_last=1, go to FILL with idx=0. No valid_in is produced from DROP.
- valid_in: high for exactly one en-high cycle per completed vector.
  - If en falls on the cycle the pulse is due, the pulse is deferred to the first cycle en is high again.
  - in_x_flat, vec_len and short_vec hold their values until the next emission.
- err_long: cleared only by rst.
- Latency: last accepted element to valid_in = 1 cycle. Throughput: one N-element vector per N cycles.
- Reset mid-vector: partial contents are discarded; no valid_in is produced after rst; idx restarts at 0.
- s_valid=0 cycles: no state change; gaps of any length inside a vector are allowed.
- Width rules:
  - idx is $clog2(N) bits and never exceeds N-1.
  - s_data is stored bit-exact; no saturation or rescaling.

Test Plan:
- Full vector: N=64, stream 8× {061D,061D,FDE2,0B13,FBCF,0B26,042B,F5BE}, last on element 63.
  -> valid_in one cycle after; in_x_flat lane0=061D, lane3=0B13, lane63=F5BE; vec_len=64; short_vec=0.
- Short vector: 5 elements {00F7,0AC0,0A99,09D6,FF4D}, last on the 5th.
  -> lanes 0-4 match the input, lanes 5-63=8000; vec_len=5; short_vec=1.
- Back-to-back: three full vectors with s_valid held high for 192 cycles.
  -> valid_in pulses at cycles 64, 128 and 192 after the first accept; no dropped elements; s_ready constantly 1.
- Over-long: 70 elements, last on the 70th, then a 64-element vector.
  -> first emission holds elements 0-63; err_long=1 from then on; elements 64-69 dropped; second vector emitted correctly.
- en gating and reset: drop en for 3 cycles when the pulse is due.
  -> valid_in appears on the first en-high cycle with data unchanged. Separately, assert rst after 20 elements.
  -> no valid_in; the next 64 elements form a clean vector.
